// File: rtl/mul_op_pkg.sv
// Shared constants for the shift-add multiplier datapath: strobe bit positions
// within a packed strobe vector, and a constant-evaluable ceil(log2) helper.
package mul_op_pkg;

  localparam int STROBE_W = 5;

  // Bit positions of the automaton micro-operation strobes in a packed vector
  localparam int T1_LOAD  = 0;
  localparam int T2_SHIFT = 1;
  localparam int T3_ADD   = 2;
  localparam int T4_DEC   = 3;
  localparam int T9_LATCH = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mul_op_addshift.sv
// Combinational add-then-shift stage: computes the next A and Q from the
// current A, Q, M and the add/shift strobes.
module mul_op_addshift #(
  parameter int W = 4
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic [W-1:0] m,
  input  logic         t2,
  input  logic         t3,
  output logic [W:0]   a_next,
  output logic [W-1:0] q_next
);

  logic [W:0] sum;

  always_comb begin
    sum = a;
    if (t3) begin
      sum = a + {1'b0, m};
    end
  end

  // Shifting the sum (not the old A) lets add and shift share one cycle
  always_comb begin
    a_next = sum;
    q_next = q;
    if (t2) begin
      a_next = {1'b0, sum[W:1]};
      q_next = {sum[0], q[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_op_unit.sv
// Operational unit of an unsigned shift-add multiplier driven by automaton strobes.
// Define MUL_OP_ERR_EN to add the sticky over-iteration flag output err.
module mul_op_unit
  import mul_op_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         t1,
  input  logic         t2,
  input  logic         t3,
  input  logic         t4,
  input  logic         t9,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         x,
  output logic         y,
  output logic [2*W-1:0] p_out,
  output logic         done
`ifdef MUL_OP_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int CW = clog2(W + 1);

  logic [STROBE_W-1:0] strobe;
  logic [W:0]          a_reg;
  logic [W:0]          a_next;
  logic [W-1:0]        q_reg;
  logic [W-1:0]        q_next;
  logic [W-1:0]        m_reg;
  logic [CW-1:0]       cnt_reg;
  logic [2*W-1:0]      p_reg;
  logic                done_reg;
  logic                cnt_zero;

  assign strobe[T1_LOAD]  = t1;
  assign strobe[T2_SHIFT] = t2;
  assign strobe[T3_ADD]   = t3;
  assign strobe[T4_DEC]   = t4;
  assign strobe[T9_LATCH] = t9;

  assign cnt_zero = (cnt_reg == '0);

  mul_op_addshift #(
    .W(W)
  ) u_addshift (
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_reg),
    .t2     (strobe[T2_SHIFT]),
    .t3     (strobe[T3_ADD]),
    .a_next (a_next),
    .q_next (q_next)
  );

  // Load takes priority over the datapath strobes for A, Q, M and CNT
  always_ff @(posedge clk) begin
    if (res) begin
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      cnt_reg <= '0;
    end else if (strobe[T1_LOAD]) begin
      a_reg   <= '0;
      q_reg   <= b_in;
      m_reg   <= a_in;
      cnt_reg <= CW'(W);
    end else begin
      a_reg <= a_next;
      q_reg <= q_next;
      if (strobe[T4_DEC] && !cnt_zero) begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  // Product latch sees pre-edge A and Q, independent of a concurrent load
  always_ff @(posedge clk) begin
    if (res) begin
      p_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= strobe[T9_LATCH];
      if (strobe[T9_LATCH]) begin
        p_reg <= {a_reg[W-1:0], q_reg};
      end
    end
  end

`ifdef MUL_OP_ERR_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (res || strobe[T1_LOAD]) begin
      err_reg <= 1'b0;
    end else if ((strobe[T2_SHIFT] || strobe[T4_DEC]) && cnt_zero) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

  assign x     = cnt_zero;
  assign y     = q_reg[0];
  assign p_out = p_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_mul_op_unit.sv
// Directed self-checking bench for mul_op_unit (W=4) with hand-computed products.
module tb_mul_op_unit;
    import mul_op_pkg::*;

    localparam int W = 4;
    localparam int TIMEOUT_NS = 100000;

    logic           clk = 1'b0;
    logic           res = 1'b1;
    logic           t1 = 1'b0;
    logic           t2 = 1'b0;
    logic           t3 = 1'b0;
    logic           t4 = 1'b0;
    logic           t9 = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           x;
    logic           y;
    logic [2*W-1:0] p_out;
    logic           done;
`ifdef MUL_OP_ERR_EN
    logic           err;
`endif

    int errors = 0;
    int checks = 0;
    logic finished = 1'b0;

    always #5 clk = ~clk;

    mul_op_unit #(
        .W(W)
    ) dut (
        .clk   (clk),
        .res   (res),
        .t1    (t1),
        .t2    (t2),
        .t3    (t3),
        .t4    (t4),
        .t9    (t9),
        .a_in  (a_in),
        .b_in  (b_in),
        .x     (x),
        .y     (y),
        .p_out (p_out),
        .done  (done)
`ifdef MUL_OP_ERR_EN
        ,
        .err   (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #(TIMEOUT_NS);
        if (!finished) begin
            $error("FAIL timeout: bench did not finish within %0d ns", TIMEOUT_NS);
            $finish;
        end
    end

    // Apply one cycle of strobes (and reset) at the falling edge, return just after the rising edge
    task automatic drive(input logic [STROBE_W-1:0] s, input logic r);
        @(negedge clk);
        res = r;
        t1  = s[T1_LOAD];
        t2  = s[T2_SHIFT];
        t3  = s[T3_ADD];
        t4  = s[T4_DEC];
        t9  = s[T9_LATCH];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [STROBE_W-1:0] iter_strobe(input logic add);
        logic [STROBE_W-1:0] s;
        s = '0;
        s[T2_SHIFT] = 1'b1;
        s[T4_DEC]   = 1'b1;
        s[T3_ADD]   = add;
        return s;
    endfunction

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic noisy);
        logic [STROBE_W-1:0] s;
        s = '0;
        s[T1_LOAD] = 1'b1;
        if (noisy) begin
            s[T2_SHIFT] = 1'b1;
            s[T3_ADD]   = 1'b1;
            s[T4_DEC]   = 1'b1;
        end
        a_in = a;
        b_in = b;
        drive(s, 1'b0);
    endtask

    task automatic multiply(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] prod, input logic noisy);
        logic [STROBE_W-1:0] s;
        load(a, b, noisy);
        for (int i = 0; i < W; i++) begin
            check("iter_y", y, b[i]);
            check("iter_x", x, 1'b0);
            drive(iter_strobe(b[i]), 1'b0);
        end
        check("end_x", x, 1'b1);
        s = '0;
        s[T9_LATCH] = 1'b1;
        drive(s, 1'b0);
        check("t9_done", done, 1'b1);
        check("t9_prod", p_out, prod);
        drive('0, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_prod", p_out, prod);
    endtask

    initial begin
        logic [STROBE_W-1:0] s;

        // Reset
        drive('0, 1'b1);
        check("rst_x", x, 1'b1);
        check("rst_y", y, 1'b0);
        check("rst_p", p_out, 8'd0);
        check("rst_done", done, 1'b0);
        $display("txn reset x=%0b y=%0b p=%0d done=%0b", x, y, p_out, done);

        multiply(4'd5, 4'd3, 8'd15, 1'b0);
        $display("txn 5*3 p=%0d", p_out);

        multiply(4'd15, 4'd15, 8'd225, 1'b0);
        $display("txn 15*15 p=%0d", p_out);

        // Load with shift/add/decrement asserted: those must be ignored
        load(4'd9, 4'd6, 1'b1);
        check("noisy_load_x", x, 1'b0);
        check("noisy_load_y", y, 1'b0);
        multiply(4'd9, 4'd6, 8'd54, 1'b1);
        $display("txn noisy-load 9*6 p=%0d", p_out);

        // Over-iteration: counter saturates at zero
        s = '0;
        s[T4_DEC] = 1'b1;
        drive(s, 1'b0);
        check("sat1_x", x, 1'b1);
`ifdef MUL_OP_ERR_EN
        check("sat1_err", err, 1'b1);
`endif
        drive(s, 1'b0);
        check("sat2_x", x, 1'b1);
        check("sat2_p", p_out, 8'd54);
`ifdef MUL_OP_ERR_EN
        check("sat2_err", err, 1'b1);
        drive('0, 1'b0);
        check("sat_hold_err", err, 1'b1);
        load(4'd1, 4'd1, 1'b0);
        check("load_clr_err", err, 1'b0);
`endif
        $display("txn saturate x=%0b", x);

        // Reset in the middle of a multiply, with iteration strobes active
        load(4'd13, 4'd11, 1'b0);
        drive(iter_strobe(1'b1), 1'b0);
        drive(iter_strobe(1'b1), 1'b0);
        check("mid_x", x, 1'b0);
        drive(iter_strobe(1'b1), 1'b1);
        check("midrst_x", x, 1'b1);
        check("midrst_y", y, 1'b0);
        check("midrst_p", p_out, 8'd0);
        check("midrst_done", done, 1'b0);
        $display("txn mid-reset x=%0b y=%0b p=%0d", x, y, p_out);

        multiply(4'd2, 4'd7, 8'd14, 1'b0);
        $display("txn 2*7 p=%0d", p_out);

        // t9 held two cycles gives two done cycles
        s = '0;
        s[T9_LATCH] = 1'b1;
        drive(s, 1'b0);
        check("hold1_done", done, 1'b1);
        drive(s, 1'b0);
        check("hold2_done", done, 1'b1);
        check("hold2_p", p_out, 8'd14);
        drive('0, 1'b0);
        check("hold_end_done", done, 1'b0);
        $display("txn t9-hold done=%0b p=%0d", done, p_out);

        finished = 1'b1;
        if (errors != 0) begin
            $error("FAIL summary: %0d of %0d checks failed", errors, checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
